// File: rtl/systolic_array_ctrl.sv
// rtl/systolic_array_ctrl.sv - job sequencer for the weight-stationary systolic_array
// Optional stall counter built when SA_CTRL_PERF_CNT_EN is defined.
module systolic_array_ctrl #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_LAT  = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_VECS   = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [$clog2(MAX_VECS+1)-1:0]   cmd_num_vecs,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [DATA_WIDTH-1:0]           w_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SIZE*DATA_WIDTH-1:0]      in_data,
  output logic                            sa_load_weights,
  output logic [DATA_WIDTH-1:0]           sa_weight_data,
  output logic [$clog2(SIZE*SIZE)-1:0]    sa_weight_mem,
  output logic                            sa_start,
  output logic [SIZE*DATA_WIDTH-1:0]      sa_in_data,
  input  logic [SIZE*DATA_WIDTH-1:0]      sa_out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SIZE*DATA_WIDTH-1:0]      out_data,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     stall_cycles
);

  localparam int VW  = $clog2(MAX_VECS+1);
  localparam int WN  = SIZE*SIZE;
  localparam int IW  = $clog2(WN);
  localparam int TL  = ARRAY_LAT+SIZE;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH+TL+1);
  localparam int VDW = SIZE*DATA_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t          state, state_n;
  logic [VW-1:0]   num_vecs_q, issued;
  logic [IW-1:0]   w_idx;
  logic            first_q;
  logic [TL-1:0]   tag;
  logic [CW-1:0]   in_flight, fifo_count;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [VDW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [VDW-1:0]  aligned;
  logic            cmd_fire, w_fire, in_fire, push, pop, credit_ok;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign w_fire    = w_valid & w_ready;
  assign in_fire   = in_valid & in_ready;
  assign push      = tag[TL-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_mem[rd_ptr];
  // Credits cover every vector still inside the array, so a push never finds the FIFO full.
  assign credit_ok = (in_flight + fifo_count) < CW'(FIFO_DEPTH);

  always_comb begin
    state_n         = state;
    cmd_ready       = 1'b0;
    w_ready         = 1'b0;
    in_ready        = 1'b0;
    sa_load_weights = 1'b0;
    sa_weight_data  = '0;
    sa_weight_mem   = '0;
    sa_start        = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && !rst) state_n = S_LOAD_W;
      end
      S_LOAD_W: begin
        busy            = 1'b1;
        w_ready         = 1'b1;
        sa_load_weights = w_valid;
        sa_weight_data  = w_data;
        sa_weight_mem   = w_idx;
        if (w_valid && w_idx == IW'(WN-1))
          state_n = (num_vecs_q == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        busy     = 1'b1;
        sa_start = first_q;
        in_ready = (issued < num_vecs_q) && credit_ok;
        if (issued == num_vecs_q) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (tag == '0 && fifo_count == '0) state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      num_vecs_q <= '0;
      issued     <= '0;
      w_idx      <= '0;
      first_q    <= 1'b0;
      tag        <= '0;
      in_flight  <= '0;
    end else begin
      state   <= state_n;
      first_q <= (state == S_LOAD_W) && (state_n == S_STREAM);
      tag     <= {tag[TL-2:0], in_fire};
      if (cmd_fire) begin
        num_vecs_q <= cmd_num_vecs;
        issued     <= '0;
        w_idx      <= '0;
      end else begin
        if (in_fire && issued != '1) issued <= issued + 1'b1;
        if (w_fire && w_idx != '1)   w_idx  <= w_idx + 1'b1;
      end
      case ({in_fire, push})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) fifo_mem[k] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= aligned;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // Lane i is delayed i cycles past the lane-0 register; bubbles shift in zeros.
  for (genvar i = 0; i < SIZE; i++) begin : g_skew
    logic [DATA_WIDTH-1:0] sk [0:i];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= i; k++) sk[k] <= '0;
      end else begin
        sk[0] <= in_fire ? in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int k = 1; k <= i; k++) sk[k] <= sk[k-1];
      end
    end
    assign sa_in_data[i*DATA_WIDTH +: DATA_WIDTH] = sk[i];
  end

  // Result lane j arrives j cycles after lane 0; SIZE-j registers line all lanes up on the push cycle.
  for (genvar j = 0; j < SIZE; j++) begin : g_deskew
    logic [DATA_WIDTH-1:0] dl [0:SIZE-1-j];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= SIZE-1-j; k++) dl[k] <= '0;
      end else begin
        dl[0] <= sa_out_data[j*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 1; k <= SIZE-1-j; k++) dl[k] <= dl[k-1];
      end
    end
    assign aligned[j*DATA_WIDTH +: DATA_WIDTH] = dl[SIZE-1-j];
  end

`ifdef SA_CTRL_PERF_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (cmd_fire) begin
      stall_q <= '0;
    end else if (((state == S_STREAM) && in_valid && !in_ready) || (out_valid && !out_ready)) begin
      if (stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb/tb_systolic_array_ctrl.sv - directed job table and corner sequences for systolic_array_ctrl
// Includes a behavioural weight-stationary array model driving sa_out_data.
module tb_systolic_array_ctrl;
  localparam int S = 3, DW = 16, L = 3, FD = 8, MV = 255;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_num_vecs;
  logic          w_valid, w_ready;
  logic [15:0]   w_data;
  logic          in_valid, in_ready;
  logic [47:0]   in_data;
  logic          sa_load_weights;
  logic [15:0]   sa_weight_data;
  logic [3:0]    sa_weight_mem;
  logic          sa_start;
  logic [47:0]   sa_in_data, sa_out_data;
  logic          out_valid, out_ready;
  logic [47:0]   out_data;
  logic          busy, done;
  logic [31:0]   stall_cycles;

  systolic_array_ctrl #(.SIZE(S), .DATA_WIDTH(DW), .ARRAY_LAT(L), .FIFO_DEPTH(FD), .MAX_VECS(MV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_vecs(cmd_num_vecs),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sa_load_weights(sa_load_weights), .sa_weight_data(sa_weight_data), .sa_weight_mem(sa_weight_mem),
    .sa_start(sa_start), .sa_in_data(sa_in_data), .sa_out_data(sa_out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: y[j] = sum_i x[i]*W[i][j]; lane j shows up ARRAY_LAT+j cycles after issue.
  logic [15:0] wmem [0:8];
  logic [47:0] hist [0:7];
  always @(posedge clk) begin
    if (sa_load_weights) wmem[sa_weight_mem] <= sa_weight_data;
    hist[0] <= sa_in_data;
    for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
  end
  always_comb begin
    logic [15:0] acc;
    logic [47:0] v;
    int d;
    sa_out_data = '0;
    for (int j = 0; j < S; j++) begin
      acc = '0;
      for (int i = 0; i < S; i++) begin
        d = L + j - 1 - i;
        if (d == 0) v = sa_in_data;
        else        v = hist[d-1];
        acc = acc + 16'(wmem[i*S+j] * v[i*DW +: DW]);
      end
      sa_out_data[j*DW +: DW] = acc;
    end
  end

  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cnt = 0, start_cnt = 0, acc_count = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done)     done_cnt  <= done_cnt + 1;
    if (sa_start) start_cnt <= start_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [15:0] wval(input int kind, input int k);
    if (kind == 0) return (k % 4 == 0) ? 16'd1 : 16'd0;
    if (kind == 1) return 16'd2;
    return 16'(k + 1);
  endfunction

  typedef struct { logic [47:0] vin; logic [47:0] vexp; } vec_t;
  typedef struct { int first; int nv; int wkind; int hold; } job_t;
  vec_t vt [0:31];
  job_t jt [0:3];

  task automatic load_weights(input int kind);
    for (int k = 0; k < 9; k++) begin
      w_valid = 1'b1;
      w_data  = wval(kind, k);
      #1;
      check("w_beat", {sa_load_weights, w_ready, sa_weight_mem, sa_weight_data},
            {1'b1, 1'b1, 4'(k), wval(kind, k)});
      @(negedge clk);
    end
    w_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [47:0] d, output int acc_cyc);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 400) begin
      @(negedge clk); #1; n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    acc_count++;
  endtask

  task automatic run_job(input job_t j);
    int got = 0, first_v = -1, acc0 = 0, d0, s0, t = 0, ac;
    bit seen_done = 0, was_held = 0;
    logic [47:0] held;
    int times [0:15];
    out_ready    = (j.hold == 0);
    cmd_valid    = 1'b1;
    cmd_num_vecs = 8'(j.nv);
    #1 check("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    d0 = done_cnt; s0 = start_cnt; acc_count = 0;
    #1 check("busy_after_cmd", busy, 1'b1);
    fork
      begin
        load_weights(j.wkind);
        for (int v = 0; v < j.nv; v++) begin
          send_vec(vt[j.first+v].vin, ac);
          if (v == 0) acc0 = ac;
        end
        in_valid = 1'b0;
      end
      begin
        if (j.hold > 0) begin
          repeat (j.hold) @(negedge clk);
          check("credit_limit", acc_count, FD);
          out_ready = 1'b1;
        end
      end
      begin
        while (!seen_done && t < 3000) begin
          @(negedge clk); #2; t++;
          if (out_valid && first_v < 0) first_v = cyc;
          if (out_valid && !out_ready) begin
            if (was_held) check("out_hold_stable", out_data, held);
            was_held = 1; held = out_data;
          end else was_held = 0;
          if (out_valid && out_ready) begin
            if (got < j.nv) check("out_data", out_data, vt[j.first+got].vexp);
            if (got < 16) times[got] = cyc;
            got++;
          end
          if (done) seen_done = 1;
        end
      end
    join
    check("done_seen", seen_done, 1'b1);
    check("out_count", got, j.nv);
    @(negedge clk); #1;
    check("done_one_cycle", {done, busy, cmd_ready}, 3'b001);
    check("done_pulses", done_cnt - d0, 1);
    check("sa_start_pulses", start_cnt - s0, (j.nv > 0) ? 1 : 0);
    if (j.nv == 0) check("no_out_valid", first_v < 0, 1'b1);
    if (j.nv == 1 && j.hold == 0) check("latency", first_v - acc0, L + S + 1);
    if (j.nv == 4 && got == 4)
      for (int k = 1; k < 4; k++) check("throughput", times[k] - times[k-1], 1);
  endtask

  initial begin
    int d0, ac, n;
    vt[0] = '{pk(1, 2, 3), pk(1, 2, 3)};
    for (int k = 1; k <= 4; k++)
      vt[k] = '{pk(16'(k), 16'(k), 16'(k)), pk(16'(6*k), 16'(6*k), 16'(6*k))};
    for (int k = 1; k <= 12; k++)
      vt[4+k] = '{pk(16'(k), 16'd1, 16'd0), pk(16'(k+4), 16'(2*k+5), 16'(3*k+6))};
    jt[0] = '{0, 1, 0, 0};
    jt[1] = '{1, 4, 1, 0};
    jt[2] = '{5, 12, 2, 20};
    jt[3] = '{0, 0, 1, 0};

    rst = 1'b1; cmd_valid = 0; cmd_num_vecs = 0; w_valid = 0; w_data = 0;
    in_valid = 0; in_data = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl", {cmd_ready, busy, done, out_valid, in_ready, w_ready, sa_start, sa_load_weights}, 8'h00);
    check("rst_sa_in", sa_in_data, 48'h0);
    check("rst_out_data", out_data, 48'h0);
    check("rst_stall", stall_cycles, 32'h0);
    @(negedge clk); rst = 1'b0;
    #1 check("idle_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_job(jt[i]);

    // Reset in the third STREAM cycle.
    cmd_valid = 1'b1; cmd_num_vecs = 8'd4; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; d0 = done_cnt;
    load_weights(1);
    #1 check("stream_first_start", sa_start, 1'b1);
    send_vec(pk(1, 1, 1), ac);
    send_vec(pk(2, 2, 2), ac);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("midrst_ctrl", {busy, out_valid, cmd_ready, in_ready, done}, 5'b0);
    check("midrst_sa_in", sa_in_data, 48'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_quiet", {out_valid, busy, cmd_ready}, 3'b001);
    @(negedge clk);
    run_job(jt[1]);

    // Result held back by out_ready for five cycles.
    out_ready = 1'b0; cmd_valid = 1'b1; cmd_num_vecs = 8'd1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    load_weights(0);
    send_vec(pk(7, 8, 9), ac);
    in_valid = 1'b0;
    n = 0;
    #1;
    while (!out_valid && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("perf_out_valid", out_valid, 1'b1);
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    #1 check("perf_out_data", out_data, pk(7, 8, 9));
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("perf_done", done, 1'b1);
`ifdef SA_CTRL_PERF_CNT_EN
    check("stall_cycles", stall_cycles, 32'd5);
`else
    check("stall_cycles", stall_cycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
